// File: rtl/red_pitaya_fads_sorter.sv
// Fluorescence-activated droplet sorter: measures width and peak of each
// droplet on channel A and fires a delayed ASG trigger for accepted ones.
module red_pitaya_fads_sorter #(
    parameter int CW = 16
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic signed [13:0]   adc_a_i,
    input  logic                 cfg_enable_i,
    input  logic signed [13:0]   cfg_low_thr_i,
    input  logic signed [13:0]   cfg_high_thr_i,
    input  logic [CW-1:0]        cfg_min_width_i,
    input  logic [CW-1:0]        cfg_max_width_i,
    input  logic [CW-1:0]        cfg_delay_i,
    input  logic [CW-1:0]        cfg_pulse_len_i,
    output logic                 asg_trig_o,
    output logic [1:0]           state_o,
    output logic [31:0]          droplet_cnt_o,
    output logic [31:0]          sort_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DELAY   = 2'd2,
        FIRE    = 2'd3
    } state_t;

    state_t             state_q;
    logic signed [13:0] adc_q;
    logic               present_q;
    logic [CW-1:0]      width_q;
    logic signed [13:0] peak_q;
    logic [CW-1:0]      dly_cnt_q;
    logic [CW-1:0]      pulse_cnt_q;
    logic               trig_q;
    logic [31:0]        drop_cnt_q;
    logic [31:0]        sort_cnt_q;

    logic               present_s;
    logic               rise_s;
    logic               accept_s;
    logic [CW-1:0]      width_inc_s;
    logic signed [13:0] peak_max_s;
    logic [CW-1:0]      pulse_load_s;

    assign present_s    = (adc_q > cfg_low_thr_i);
    assign rise_s       = present_s && !present_q;
    assign width_inc_s  = (width_q == {CW{1'b1}}) ? width_q : (width_q + {{(CW-1){1'b0}}, 1'b1});
    assign peak_max_s   = (adc_q > peak_q) ? adc_q : peak_q;
    assign accept_s     = (width_q >= cfg_min_width_i) && (width_q <= cfg_max_width_i) &&
                          (peak_q < cfg_high_thr_i);
    // A zero pulse length still produces a single-cycle trigger.
    assign pulse_load_s = (cfg_pulse_len_i == {CW{1'b0}}) ? {{(CW-1){1'b0}}, 1'b1} : cfg_pulse_len_i;

    // Sample pipeline: registered ADC value and one-cycle-delayed presence flag.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            adc_q     <= 14'sd0;
            present_q <= 1'b0;
        end else begin
            adc_q     <= adc_a_i;
            present_q <= present_s;
        end
    end

    // Sorter state machine with registered trigger and event counters.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            state_q     <= IDLE;
            width_q     <= {CW{1'b0}};
            peak_q      <= 14'sd0;
            dly_cnt_q   <= {CW{1'b0}};
            pulse_cnt_q <= {CW{1'b0}};
            trig_q      <= 1'b0;
            drop_cnt_q  <= 32'd0;
            sort_cnt_q  <= 32'd0;
        end else if (!cfg_enable_i) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Only a fresh rising edge starts a measurement.
                    if (rise_s) begin
                        state_q <= MEASURE;
                        width_q <= {{(CW-1){1'b0}}, 1'b1};
                        peak_q  <= adc_q;
                    end
                end
                MEASURE: begin
                    if (present_s) begin
                        width_q <= width_inc_s;
                        peak_q  <= peak_max_s;
                    end else begin
                        drop_cnt_q <= drop_cnt_q + 32'd1;
                        if (accept_s) begin
                            sort_cnt_q  <= sort_cnt_q + 32'd1;
                            dly_cnt_q   <= cfg_delay_i;
                            pulse_cnt_q <= pulse_load_s;
                            if (cfg_delay_i == {CW{1'b0}}) begin
                                state_q <= FIRE;
                                trig_q  <= 1'b1;
                            end else begin
                                state_q <= DELAY;
                            end
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DELAY: begin
                    if (dly_cnt_q <= {{(CW-1){1'b0}}, 1'b1}) begin
                        state_q <= FIRE;
                        trig_q  <= 1'b1;
                    end else begin
                        dly_cnt_q <= dly_cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                FIRE: begin
                    if (pulse_cnt_q <= {{(CW-1){1'b0}}, 1'b1}) begin
                        state_q <= IDLE;
                        trig_q  <= 1'b0;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q <= IDLE;
                    trig_q  <= 1'b0;
                end
            endcase
        end
    end

    assign asg_trig_o    = trig_q;
    assign state_o       = state_q;
    assign droplet_cnt_o = drop_cnt_q;
    assign sort_cnt_o    = sort_cnt_q;

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// Bench for the droplet sorter: directed scenarios plus randomized droplet
// trains checked against a droplet-level reference model.
module tb_red_pitaya_fads_sorter;
    localparam int CW   = 16;
    localparam int NMAX = 400;
    localparam int B    = -8000;

    logic               clk = 1'b0;
    logic               rstn;
    logic signed [13:0] adc_a;
    logic               en;
    logic signed [13:0] low, high;
    logic [CW-1:0]      minw, maxw, dly, plen;
    logic               trig;
    logic [1:0]         st;
    logic [31:0]        dcnt, scnt;

    int n_cmp = 0;
    int n_err = 0;
    int mdrop = 0;
    int msort = 0;
    int samp [NMAX];
    int nsamp;
    int etrig [NMAX];
    int estate[NMAX];

    red_pitaya_fads_sorter #(.CW(CW)) dut (
        .adc_clk_i       (clk),
        .adc_rstn_i      (rstn),
        .adc_a_i         (adc_a),
        .cfg_enable_i    (en),
        .cfg_low_thr_i   (low),
        .cfg_high_thr_i  (high),
        .cfg_min_width_i (minw),
        .cfg_max_width_i (maxw),
        .cfg_delay_i     (dly),
        .cfg_pulse_len_i (plen),
        .asg_trig_o      (trig),
        .state_o         (st),
        .droplet_cnt_o   (dcnt),
        .sort_cnt_o      (scnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int v);
        adc_a = 14'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            samp[nsamp] = v;
            nsamp++;
        end
    endtask

    task automatic set_cfg(input int l, input int h, input int mn, input int mx, input int d, input int p);
        low = 14'(l); high = 14'(h);
        minw = CW'(mn); maxw = CW'(mx); dly = CW'(d); plen = CW'(p);
    endtask

    // Droplet-level model: find runs above threshold, decide each one that
    // starts while the sorter is free, and mark trigger/state per edge.
    task automatic build_model();
        int k, s, e, free_e, w, pk, pl, base;
        for (int j = 0; j < NMAX; j++) begin
            etrig[j] = 0;
            estate[j] = 0;
        end
        free_e = 0;
        k = 1;
        while (k < nsamp) begin
            if (samp[k] > int'(low) && samp[k-1] <= int'(low)) begin
                s = k;
                e = k;
                while (e + 1 < nsamp && samp[e+1] > int'(low)) e++;
                if (s >= free_e) begin
                    w  = e - s + 1;
                    pk = samp[s];
                    for (int j = s; j <= e; j++) if (samp[j] > pk) pk = samp[j];
                    for (int j = s + 1; j <= e + 1 && j < NMAX; j++) estate[j] = 1;
                    mdrop++;
                    if (w >= int'(minw) && w <= int'(maxw) && pk < int'(high)) begin
                        msort++;
                        pl   = (plen == '0) ? 1 : int'(plen);
                        base = e + 2 + int'(dly);
                        for (int j = e + 2; j < base && j < NMAX; j++) estate[j] = 2;
                        for (int j = base; j < base + pl && j < NMAX; j++) begin
                            estate[j] = 3;
                            etrig[j]  = 1;
                        end
                        free_e = base + pl;
                    end else begin
                        free_e = e + 2;
                    end
                end
                k = e + 1;
            end else begin
                k++;
            end
        end
    endtask

    task automatic run_seq(input string tag);
        build_model();
        for (int k = 0; k < nsamp; k++) begin
            step(samp[k]);
            check({tag, " trig"}, 32'(trig), 32'(etrig[k]));
            check({tag, " state"}, 32'(st), 32'(estate[k]));
        end
        check({tag, " droplet_cnt"}, dcnt, 32'(mdrop));
        check({tag, " sort_cnt"}, scnt, 32'(msort));
    endtask

    task automatic gen_random();
        int lo, hi_span, gap_span;
        lo       = int'(low);
        hi_span  = int'(high) + 300 - (lo + 1);
        gap_span = lo + 8000;
        nsamp = 0;
        push(B, 3);
        while (nsamp < NMAX - 80) begin
            push(lo + 1 + int'($urandom_range(hi_span, 0)), 1);
            for (int i = int'($urandom_range(12, 0)); i > 0; i--)
                push(lo + 1 + int'($urandom_range(hi_span, 0)), 1);
            for (int i = int'($urandom_range(20, 1)); i > 0; i--)
                push(lo - int'($urandom_range(gap_span, 0)), 1);
        end
        push(B, 40);
    endtask

    initial begin
        rstn = 1'b0;
        en   = 1'b1;
        adc_a = 14'sd0;
        set_cfg(100, 1000, 3, 10, 5, 4);
        step(B); step(B); step(B);
        check("reset trig", 32'(trig), 32'd0);
        check("reset state", 32'(st), 32'd0);
        check("reset droplet_cnt", dcnt, 32'd0);
        check("reset sort_cnt", scnt, 32'd0);
        rstn = 1'b1;
        step(B); step(B);

        nsamp = 0; push(B, 3); push(500, 5); push(B, 30);
        run_seq("basic");

        nsamp = 0; push(B, 3); push(500, 1); push(800, 1); push(1200, 1); push(600, 1); push(B, 30);
        run_seq("peak_reject");

        nsamp = 0; push(B, 3);
        push(500, 2); push(B, 20); push(500, 11); push(B, 20);
        push(500, 3); push(B, 20); push(500, 10); push(B, 20);
        run_seq("width_bounds");

        set_cfg(100, 1000, 3, 10, 0, 0);
        nsamp = 0; push(B, 3); push(500, 4); push(B, 20);
        run_seq("zero_delay");

        set_cfg(100, 1000, 3, 10, 5, 4);
        nsamp = 0; push(B, 3); push(500, 5); push(B, 1); push(500, 3); push(B, 1);
        push(500, 10); push(B, 30);
        run_seq("ignored");

        // Config changes after the decision must not affect the ongoing sort.
        step(B); step(B); step(B);
        for (int i = 0; i < 5; i++) step(500);
        step(B);
        step(B);
        check("latch state", 32'(st), 32'd2);
        mdrop++; msort++;
        dly = CW'(1); plen = CW'(1);
        for (int i = 2; i <= 10; i++) begin
            step(B);
            check("latch trig", 32'(trig), (i >= 6 && i <= 9) ? 32'd1 : 32'd0);
        end
        check("latch end state", 32'(st), 32'd0);
        set_cfg(100, 1000, 3, 10, 5, 4);

        step(B); step(B); step(B);
        for (int i = 0; i < 5; i++) step(500);
        step(B);
        step(B);
        mdrop++; msort++;
        check("en delay state", 32'(st), 32'd2);
        en = 1'b0;
        step(B);
        check("en off state", 32'(st), 32'd0);
        for (int i = 0; i < 5; i++) step(500);
        for (int i = 0; i < 10; i++) begin
            step(B);
            check("en off trig", 32'(trig), 32'd0);
        end
        check("en off droplet_cnt", dcnt, 32'(mdrop));
        check("en off sort_cnt", scnt, 32'(msort));
        en = 1'b1;
        step(B); step(B); step(B);

        set_cfg(100, 1000, 3, 10, 0, 8);
        for (int i = 0; i < 4; i++) step(500);
        step(B);
        step(B);
        check("pre-reset trig", 32'(trig), 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("async reset trig", 32'(trig), 32'd0);
        check("async reset state", 32'(st), 32'd0);
        check("async reset droplet_cnt", dcnt, 32'd0);
        check("async reset sort_cnt", scnt, 32'd0);
        mdrop = 0; msort = 0;
        step(B); step(B);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(B);
            check("post-reset trig", 32'(trig), 32'd0);
            check("post-reset state", 32'(st), 32'd0);
        end

        for (int ph = 0; ph < 5; ph++) begin
            int lo;
            case ($urandom_range(2, 0))
                0: lo = 100;
                1: lo = -50;
                default: lo = 2000;
            endcase
            set_cfg(lo, lo + 200 + int'($urandom_range(2800, 0)),
                    0, 0, int'($urandom_range(8, 0)), int'($urandom_range(6, 0)));
            minw = CW'($urandom_range(5, 1));
            maxw = minw + CW'($urandom_range(7, 0));
            gen_random();
            run_seq("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
